// File: rtl/bigmac_pkg.sv
// Constants and helpers shared by bigmac and bigmac_unmac.
// mac_feedback is the feedback term f(v): the product is truncated to w bits, then shifted.
package bigmac_pkg;

  localparam int mac_coeff_c   = 27;
  localparam int mac_shift_c   = 5;
  localparam int unmac_width_c = 10;

  typedef enum logic [1:0] {
    buf_empty_e,
    buf_one_e,
    buf_full_e
  } buf_state_t;

  // Recovered sample plus its out-of-range flag; data width tracks unmac_width_c.
  typedef struct packed {
    logic [unmac_width_c-1:0] data;
    logic                     err;
  } unmac_entry_t;

  function automatic logic [63:0] mac_feedback(input logic [63:0] v, input int unsigned w);
    logic [63:0] prod;
    prod = v * 64'(mac_coeff_c);
    if (w < 32'd64) prod = prod & ((64'd1 << w) - 64'd1);
    return prod >> mac_shift_c;
  endfunction

endpackage

// File: rtl/unmac_skid_fifo.sv
// Two-entry valid/ready skid FIFO; data appears at the head one cycle after push.
// ready_o and valid_o are registered from occupancy only, so ready_o never depends on ready_i.
module unmac_skid_fifo
  import bigmac_pkg::*;
#(
  parameter int width_p = 11
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i
);

  buf_state_t         state_q;
  logic [width_p-1:0] head_q;
  logic [width_p-1:0] tail_q;
  logic               push;
  logic               pop;

  assign push   = valid_i & ready_o;
  assign pop    = valid_o & ready_i;
  assign data_o = head_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= buf_empty_e;
      head_q  <= '0;
      tail_q  <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      case (state_q)
        buf_empty_e: begin
          if (push) begin
            head_q  <= data_i;
            state_q <= buf_one_e;
            valid_o <= 1'b1;
          end
        end
        buf_one_e: begin
          if (push && pop) begin
            head_q <= data_i;
          end else if (push) begin
            tail_q  <= data_i;
            state_q <= buf_full_e;
            ready_o <= 1'b0;
          end else if (pop) begin
            state_q <= buf_empty_e;
            valid_o <= 1'b0;
          end
        end
        buf_full_e: begin
          // ready_o is low here, so a pop is the only possible event
          if (pop) begin
            head_q  <= tail_q;
            state_q <= buf_one_e;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state_q <= buf_empty_e;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bigmac_unmac.sv
// Inverse bigmac: x[n] = y[n] - f(y[n-1]), flagged when the residual exceeds width_p bits.
// One cycle latency through a 2-entry skid buffer; ready_o drops only when the buffer is full.
module bigmac_unmac
  import bigmac_pkg::*;
#(
  parameter int width_p = unmac_width_c
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [2*width_p-1:0] data_i,
  input  logic                 first_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [width_p-1:0]   data_o,
  output logic                 err_o,
  input  logic                 ready_i,
  output logic                 err_sticky_o,
  output logic [15:0]          count_o
);

  localparam int yw_lp = 2 * width_p;

  logic [yw_lp-1:0] prev_q;
  logic [yw_lp-1:0] hist;
  logic [yw_lp-1:0] fb;
  logic [yw_lp-1:0] resid;
  logic             err;
  logic             accept;
  unmac_entry_t     push_entry;
  unmac_entry_t     head_entry;

  assign accept = valid_i & ready_o;
  assign hist   = first_i ? '0 : prev_q;
  assign fb     = yw_lp'(mac_feedback(64'(hist), yw_lp));
  assign resid  = data_i - fb;
  assign err    = |resid[yw_lp-1:width_p];

  assign push_entry.data = resid[width_p-1:0];
  assign push_entry.err  = err;

  // History is the raw accumulated input, so it stays in step with the upstream bigmac
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prev_q       <= '0;
      count_o      <= '0;
      err_sticky_o <= 1'b0;
    end else if (accept) begin
      prev_q       <= data_i;
      count_o      <= count_o + 16'd1;
      err_sticky_o <= err_sticky_o | err;
    end
  end

  unmac_skid_fifo #(
    .width_p($bits(unmac_entry_t))
  ) u_skid (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (push_entry),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (head_entry),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  assign data_o = head_entry.data;
  assign err_o  = head_entry.err;

endmodule

// File: tb/tb_bigmac_unmac.sv
// Directed bench for bigmac_unmac (width_p = 10) with hand-computed expected samples.
module tb_bigmac_unmac;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [19:0] data_i = '0;
  logic        first_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        valid_o;
  logic [9:0]  data_o;
  logic        err_o;
  logic        ready_i = 1'b1;
  logic        err_sticky_o;
  logic [15:0] count_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  bigmac_unmac #(.width_p(10)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .data_i      (data_i),
    .first_i     (first_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .err_o       (err_o),
    .ready_i     (ready_i),
    .err_sticky_o(err_sticky_o),
    .count_o     (count_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle after the accepting edge.
  task automatic push1(input logic [19:0] y, input logic f);
    int n;
    n = 0;
    data_i  = y;
    first_i = f;
    valid_i = 1'b1;
    while (!ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) chk("accept_timeout", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    first_i = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [9:0] d, input logic e);
    chk({tag, "_vld"}, 32'(valid_o), 32'd1);
    chk({tag, "_dat"}, 32'(data_o), 32'(d));
    chk({tag, "_err"}, 32'(err_o), 32'(e));
  endtask

  logic [19:0] bp_y [5] = '{20'd100, 20'd284, 20'd246, 20'd210, 20'd186};
  logic [9:0]  bp_x [5] = '{10'd100, 10'd200, 10'd7, 10'd3, 10'd9};

  initial begin
    int idx, k, occ;
    logic do_push, do_pop;

    repeat (3) @(negedge clk_i);
    chk("rst_vld", 32'(valid_o), 32'd0);
    chk("rst_rdy", 32'(ready_o), 32'd1);
    chk("rst_dat", 32'(data_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_sticky", 32'(err_sticky_o), 32'd0);
    chk("rst_cnt", 32'(count_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // basic inverse
    push1(20'd100, 1'b1);
    expect_out("basic0", 10'd100, 1'b0);
    push1(20'd284, 1'b0);
    expect_out("basic1", 10'd200, 1'b0);
    chk("basic_cnt", 32'(count_o), 32'd2);
    @(negedge clk_i);
    chk("basic_drain_vld", 32'(valid_o), 32'd0);

    // residual out of range, sticky flag
    push1(20'd2000, 1'b1);
    expect_out("err0", 10'd976, 1'b1);
    chk("err0_sticky", 32'(err_sticky_o), 32'd1);
    push1(20'd1688, 1'b0);
    expect_out("err1", 10'd1, 1'b0);
    chk("err1_sticky", 32'(err_sticky_o), 32'd1);

    // product truncation before the shift
    push1(20'd1048575, 1'b1);
    expect_out("trunc0", 10'd1023, 1'b1);
    push1(20'd32772, 1'b0);
    expect_out("trunc1", 10'd5, 1'b0);

    // frame restart ignores history
    push1(20'd100, 1'b1);
    expect_out("frame0", 10'd100, 1'b0);
    push1(20'd284, 1'b0);
    expect_out("frame1", 10'd200, 1'b0);
    push1(20'd50, 1'b1);
    expect_out("frame2", 10'd50, 1'b0);
    chk("frame_cnt", 32'(count_o), 32'd9);
    @(negedge clk_i);

    // backpressure: consumer stalls for 3 cycles after the first accept
    idx = 0; k = 0; occ = 0;
    for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
      ready_i = (cyc >= 1 && cyc <= 3) ? 1'b0 : 1'b1;
      valid_i = (idx < 5);
      data_i  = (idx < 5) ? bp_y[idx] : 20'd0;
      first_i = (idx == 0);
      chk("bp_occ_rdy", 32'(ready_o), 32'(occ < 2));
      chk("bp_occ_vld", 32'(valid_o), 32'(occ > 0));
      if (cyc == 2) chk("bp_full_rdy", 32'(ready_o), 32'd0);
      do_pop  = valid_o && ready_i;
      do_push = valid_i && ready_o;
      if (do_pop) begin
        chk("bp_order", 32'(data_o), 32'(bp_x[k]));
        chk("bp_err", 32'(err_o), 32'd0);
        k++;
      end
      if (do_push) idx++;
      occ = occ + int'(do_push) - int'(do_pop);
      if (occ > 2) chk("bp_overfill", 32'(occ), 32'd2);
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    first_i = 1'b0;
    chk("bp_all_out", 32'(k), 32'd5);
    chk("bp_cnt", 32'(count_o), 32'd14);

    // asynchronous reset while the buffer is full
    ready_i = 1'b0;
    push1(20'd100, 1'b1);
    push1(20'd284, 1'b0);
    chk("pre_rst_full", 32'(ready_o), 32'd0);
    #2 reset_i = 1'b1;
    #1;
    chk("arst_vld", 32'(valid_o), 32'd0);
    chk("arst_rdy", 32'(ready_o), 32'd1);
    chk("arst_cnt", 32'(count_o), 32'd0);
    chk("arst_sticky", 32'(err_sticky_o), 32'd0);
    @(negedge clk_i);
    valid_i = 1'b1;
    data_i  = 20'd500;
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("rst_no_accept_cnt", 32'(count_o), 32'd0);
    chk("rst_no_accept_vld", 32'(valid_o), 32'd0);
    reset_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    push1(20'd100, 1'b0);
    expect_out("post_rst", 10'd100, 1'b0);
    chk("post_rst_cnt", 32'(count_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
